// File: rtl/song_controller_pkg.sv
// rtl/song_controller_pkg.sv - shared types and defaults for the song sequencing controller
//
// Purpose: state encoding and default sizing used by the controller and its bench.
// Ports:   none (package).

package song_controller_pkg;

  localparam int NUM_SONGS_DEFAULT = 4;
  localparam int SONG_W_DEFAULT    = 2;

  typedef enum logic [1:0] {
    ST_PAUSED  = 2'd0,
    ST_PLAYING = 2'd1,
    ST_SWITCH  = 2'd2
  } state_e;

endpackage

// File: rtl/song_controller_if.sv
// rtl/song_controller_if.sv - front-end / player-chain signal bundle for the song controller
//
// Purpose: groups the button/keypad/song-reader inputs and the play/song/reset_player/busy
//          outputs of the controller.
// Modports:
//   master - front end side: drives events, observes controller outputs
//   slave  - controller side: consumes events, drives play/song/reset_player/busy

interface song_controller_if #(
  parameter int SONG_W = 2
);

  logic              play_button;
  logic              next_button;
  logic              keypad_valid;
  logic [3:0]        keypad_value;
  logic              song_done;
  logic              play;
  logic [SONG_W-1:0] song;
  logic              reset_player;
  logic              busy;

  modport master (
    output play_button, next_button, keypad_valid, keypad_value, song_done,
    input  play, song, reset_player, busy
  );

  modport slave (
    input  play_button, next_button, keypad_valid, keypad_value, song_done,
    output play, song, reset_player, busy
  );

endinterface

// File: rtl/song_controller.sv
// rtl/song_controller.sv - owns current song and play/pause state for the music player
//
// Purpose: turns play/next pulses, keypad selections and end-of-song into a play enable,
//          current song index and a one-cycle player restart pulse.
// Ports:
//   clk    - system clock, rising edge
//   reset  - asynchronous active-low reset
//   ctrl   - song_controller_if.slave: play_button, next_button, keypad_valid,
//            keypad_value[3:0], song_done in; play, song, reset_player, busy out

module song_controller
  import song_controller_pkg::*;
#(
  parameter int NUM_SONGS    = NUM_SONGS_DEFAULT,
  parameter int SONG_W       = SONG_W_DEFAULT,
  parameter int AUTO_ADVANCE = 1
) (
  input  logic               clk,
  input  logic               reset,
  song_controller_if.slave   ctrl
);

  state_e            state_q, state_d;
  logic [SONG_W-1:0] song_q,  song_d;
  logic              resume_q, resume_d;
  logic              keypad_ok;

  function automatic logic [SONG_W-1:0] wrap_inc(input logic [SONG_W-1:0] s);
    if (s == SONG_W'(NUM_SONGS - 1)) begin
      return '0;
    end
    return s + 1'b1;
  endfunction

  // Out-of-range selections are not events at all, so lower-priority events still get a turn.
  assign keypad_ok = ctrl.keypad_valid && ({1'b0, ctrl.keypad_value} < 5'(NUM_SONGS));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_PAUSED;
      song_q   <= '0;
      resume_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      song_q   <= song_d;
      resume_q <= resume_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    song_d   = song_q;
    resume_d = resume_q;
    unique case (state_q)
      ST_SWITCH: begin
        // One-cycle restart window; every input this cycle is dropped.
        state_d = resume_q ? ST_PLAYING : ST_PAUSED;
      end
      ST_PAUSED, ST_PLAYING: begin
        if (keypad_ok) begin
          song_d   = ctrl.keypad_value[SONG_W-1:0];
          resume_d = (state_q == ST_PLAYING);
          state_d  = ST_SWITCH;
        end else if (ctrl.next_button) begin
          song_d   = wrap_inc(song_q);
          resume_d = (state_q == ST_PLAYING);
          state_d  = ST_SWITCH;
        end else if (ctrl.song_done && state_q == ST_PLAYING) begin
          song_d   = wrap_inc(song_q);
          resume_d = (AUTO_ADVANCE != 0);
          state_d  = ST_SWITCH;
        end else if (ctrl.play_button) begin
          state_d = (state_q == ST_PAUSED) ? ST_PLAYING : ST_PAUSED;
        end
      end
      default: begin
        state_d = ST_PAUSED;
      end
    endcase
  end

  // Outputs are pure decodes of registers, so an async reset clears them immediately.
  always_comb begin
    ctrl.play         = (state_q == ST_PLAYING);
    ctrl.song         = song_q;
    ctrl.reset_player = (state_q == ST_SWITCH);
    ctrl.busy         = (state_q == ST_SWITCH);
  end

endmodule
